// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store path: access sizes, queued entry layout,
// and byte-enable to bit-mask expansion (also usable by the load extraction side).
package store_buffer_pkg;

  localparam int unsigned SB_ADDR_W = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BE_W      = DATA_W / 8;

  typedef enum logic [1:0] {
    SB = 2'b00,
    SH = 2'b01,
    SW = 2'b10
  } store_size_t;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]    data;
    logic [BE_W-1:0]      byte_en;
  } store_entry_t;

  // Expand one strobe bit per byte into a full-width bit mask.
  function automatic logic [DATA_W-1:0] lane_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < BE_W; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Execute-side store request and data-memory write port bundle.
interface store_buffer_if #(
  parameter int unsigned ADDR_W = 32
);

  logic                                    storeValid;
  logic                                    storeReady;
  logic [1:0]                              storeSrc;
  logic [ADDR_W-1:0]                       storeAddress;
  logic [store_buffer_pkg::DATA_W-1:0]     storeData;
  logic                                    storeMisaligned;
  logic                                    memValid;
  logic                                    memReady;
  logic [ADDR_W-1:0]                       memAddress;
  logic [store_buffer_pkg::DATA_W-1:0]     memWriteData;
  logic [store_buffer_pkg::BE_W-1:0]       memByteEn;
  logic                                    bufEmpty;

  modport slave (
    input  storeValid, storeSrc, storeAddress, storeData, memReady,
    output storeReady, storeMisaligned, memValid, memAddress, memWriteData,
           memByteEn, bufEmpty
  );

  modport master (
    output storeValid, storeSrc, storeAddress, storeData, memReady,
    input  storeReady, storeMisaligned, memValid, memAddress, memWriteData,
           memByteEn, bufEmpty
  );

endinterface

// File: rtl/store_buffer_align.sv
// store_align: places rs2 data on the byte lanes selected by size/offset,
// builds the strobes, and flags misaligned or reserved-size requests.
module store_align
  import store_buffer_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] raw_data,
  output logic [DATA_W-1:0] data_c,
  output logic [BE_W-1:0]   byte_en_c,
  output logic              misaligned_c
);

  logic [DATA_W-1:0] lanes;

  always_comb begin
    lanes        = '0;
    byte_en_c    = '0;
    misaligned_c = 1'b0;
    case (store_size_t'(size))
      SB: begin
        lanes     = {4{raw_data[7:0]}};
        byte_en_c = BE_W'(4'b0001 << off);
      end
      SH: begin
        lanes        = {2{raw_data[15:0]}};
        byte_en_c    = BE_W'(4'b0011 << off);
        misaligned_c = off[0];
      end
      SW: begin
        lanes        = raw_data;
        byte_en_c    = 4'b1111;
        misaligned_c = (off != 2'b00);
      end
      default: misaligned_c = 1'b1;
    endcase
    if (misaligned_c) begin
      byte_en_c = '0;
    end
    // Unselected lanes are zeroed so queued entries carry only live bytes.
    data_c = lanes & lane_mask(byte_en_c);
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: aligns store requests and queues them in a DEPTH-entry FIFO that
// drains to data memory over valid/ready. Optional tail merging: STORE_MERGE_EN.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = SB_ADDR_W
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  sb
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  store_entry_t      fifo [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              misaligned_q;

  logic [DATA_W-1:0] al_data;
  logic [BE_W-1:0]   al_be;
  logic              al_mis;
  logic [ADDR_W-1:0] word_addr;
  logic              full;
  logic              empty;
  logic              ready;
  logic              merge_hit;
  logic              accept;
  logic              push;
  logic              pop;

  store_align u_align (
    .size         (sb.storeSrc),
    .off          (sb.storeAddress[1:0]),
    .raw_data     (sb.storeData),
    .data_c       (al_data),
    .byte_en_c    (al_be),
    .misaligned_c (al_mis)
  );

  assign word_addr = {sb.storeAddress[ADDR_W-1:2], 2'b00};
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);

`ifdef STORE_MERGE_EN
  logic [PTR_W-1:0]  tail_ptr;
  logic [DATA_W-1:0] merge_mask;

  // Tail must not be the head, otherwise a merge could disturb a stalled handshake.
  assign tail_ptr   = wr_ptr - PTR_W'(1);
  assign merge_mask = lane_mask(al_be);
  assign merge_hit  = (count >= CNT_W'(2)) &&
                      (fifo[tail_ptr].addr == SB_ADDR_W'(word_addr));
  assign ready      = !full || merge_hit;
`else
  assign merge_hit  = 1'b0;
  assign ready      = !full;
`endif

  assign accept = sb.storeValid && ready && !al_mis;
  assign push   = accept && !merge_hit;
  assign pop    = !empty && sb.memReady;

  assign sb.storeReady      = ready;
  assign sb.storeMisaligned = misaligned_q;
  assign sb.memValid        = !empty;
  assign sb.bufEmpty        = empty;
  assign sb.memAddress      = ADDR_W'(fifo[rd_ptr].addr);
  assign sb.memWriteData    = fifo[rd_ptr].data;
  assign sb.memByteEn       = fifo[rd_ptr].byte_en;

  // FIFO storage, pointers, occupancy and the rejection pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      misaligned_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo[i] <= '0;
      end
    end else begin
      misaligned_q <= sb.storeValid && ready && al_mis;
      if (push) begin
        fifo[wr_ptr] <= '{addr: SB_ADDR_W'(word_addr), data: al_data, byte_en: al_be};
        wr_ptr       <= wr_ptr + PTR_W'(1);
      end
`ifdef STORE_MERGE_EN
      if (accept && merge_hit) begin
        fifo[tail_ptr].data    <= (fifo[tail_ptr].data & ~merge_mask) |
                                  (al_data & merge_mask);
        fifo[tail_ptr].byte_en <= fifo[tail_ptr].byte_en | al_be;
      end
`endif
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
